// File: rtl/bmc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bmc_pkg
// Brief    : Shared widths, typedefs and constant helpers for bmc_soft_n.
// Revision : 1.0 - initial release
// ============================================================================

package bmc_pkg;

    localparam int c_sw_limit = 6;
    localparam int c_mw_limit = 8;

    // Sized for the widest legal configuration; narrower users zero-extend.
    typedef logic [c_sw_limit-1:0] soft_t;
    typedef logic [c_mw_limit-1:0] metric_t;

    function automatic int sw_max(input int sw);
        return (1 << sw) - 1;
    endfunction

    function automatic int bm_width(input int n, input int sw);
        int range_max;
        int w;
        range_max = n * sw_max(sw);
        w = 1;
        while ((1 << w) <= range_max) begin
            w++;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bmc_min_tree.sv
`default_nettype none
// ============================================================================
// Module   : bmc_min_tree
// Brief    : Combinational min/argmin over 2^IW metrics, lowest index on ties.
// Revision : 1.0 - initial release
// ============================================================================

module bmc_min_tree
    import bmc_pkg::*;
#(
    parameter int IW = 2,
    parameter int MW = 4,
    localparam int NUM = 1 << IW
) (
    input  logic [NUM*MW-1:0] metrics,
    output logic [MW-1:0]     min_val,
    output logic [IW-1:0]     min_idx
);

    logic [MW-1:0] w_val [NUM];
    logic [IW-1:0] w_idx [NUM];

    // Pairwise reduction in place: the left operand always holds the lower
    // indices, so a strict compare keeps the lowest index on a tie.
    always_comb begin
        for (int j = 0; j < NUM; j++) begin
            w_val[j] = metrics[j*MW +: MW];
            w_idx[j] = IW'(j);
        end
        for (int s = 1; s < NUM; s = s * 2) begin
            for (int j = 0; j < NUM; j = j + 2 * s) begin
                if (w_val[j+s] < w_val[j]) begin
                    w_val[j] = w_val[j+s];
                    w_idx[j] = w_idx[j+s];
                end
            end
        end
        min_val = w_val[0];
        min_idx = w_idx[0];
    end

endmodule

`default_nettype wire

// File: rtl/bmc_soft_n.sv
`default_nettype none
// ============================================================================
// Module   : bmc_soft_n
// Brief    : Two-stage soft-decision branch metric unit with min normalisation.
//            Optional puncture erasure enabled by defining BMC_PUNCT_EN.
// Revision : 1.0 - initial release
// ============================================================================

module bmc_soft_n
    import bmc_pkg::*;
#(
    parameter int N = 2,
    parameter int SW = 3,
    parameter int PUNCT_LEN = 2,
    parameter logic [PUNCT_LEN*N-1:0] PUNCT_MASK = '1,
    localparam int MW = bm_width(N, SW),
    localparam int NH = 1 << N
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*SW-1:0]    in_soft,
    input  logic               in_sof,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NH*MW-1:0]   out_bm,
    output logic [N-1:0]       out_best
);

    localparam int c_swmax = sw_max(SW);

    logic              w_adv;
    logic              w_accept;
    logic [N-1:0]      w_keep;
    logic [NH*MW-1:0]  w_raw;
    logic [NH*MW-1:0]  w_norm;
    logic [MW-1:0]     w_min;
    logic [N-1:0]      w_argmin;
    metric_t           w_acc;
    soft_t             w_soft;

    logic              r_s1_valid;
    logic [NH*MW-1:0]  r_raw;
    logic              r_out_valid;
    logic [NH*MW-1:0]  r_bm;
    logic [N-1:0]      r_best;

    // Stage 1 may refill whenever it is empty, even while the output stalls.
    assign w_adv    = ~r_out_valid | out_ready;
    assign in_ready = ~r_s1_valid | w_adv;
    assign w_accept = in_valid & in_ready;

`ifdef BMC_PUNCT_EN
    localparam int c_pw = (PUNCT_LEN > 1) ? $clog2(PUNCT_LEN) : 1;

    logic [c_pw-1:0] r_phase;
    logic [c_pw-1:0] w_phase_use;
    logic [c_pw-1:0] w_phase_next;

    always_comb begin
        w_phase_use  = in_sof ? '0 : r_phase;
        w_phase_next = (int'(w_phase_use) == PUNCT_LEN - 1) ? '0 : w_phase_use + c_pw'(1);
        w_keep       = N'(PUNCT_MASK >> (int'(w_phase_use) * N));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
        end else if (w_accept) begin
            r_phase <= w_phase_next;
        end
    end
`else
    logic w_unused_sof;

    assign w_keep       = '1;
    assign w_unused_sof = in_sof;
`endif

    // Erased bits add zero to every hypothesis, leaving the ordering to the rest.
    always_comb begin
        w_raw  = '0;
        w_acc  = '0;
        w_soft = '0;
        for (int h = 0; h < NH; h++) begin
            w_acc = '0;
            for (int i = 0; i < N; i++) begin
                w_soft = soft_t'(in_soft[i*SW +: SW]);
                if (w_keep[i]) begin
                    w_acc = w_acc + metric_t'(h[i] ? (soft_t'(c_swmax) - w_soft) : w_soft);
                end
            end
            w_raw[h*MW +: MW] = w_acc[MW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_raw      <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_raw <= w_raw;
            end
        end
    end

    bmc_min_tree #(
        .IW (N),
        .MW (MW)
    ) u_min_tree (
        .metrics (r_raw),
        .min_val (w_min),
        .min_idx (w_argmin)
    );

    always_comb begin
        w_norm = '0;
        for (int h = 0; h < NH; h++) begin
            w_norm[h*MW +: MW] = r_raw[h*MW +: MW] - w_min;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_bm        <= '0;
            r_best      <= '0;
        end else if (w_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_bm   <= w_norm;
                r_best <= w_argmin;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_bm    = r_bm;
    assign out_best  = r_best;

endmodule

`default_nettype wire

// File: tb/tb_bmc_soft_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_bmc_soft_n
// Brief    : Directed scoreboard bench for bmc_soft_n (N=2; SW=3 and SW=1).
// Revision : 1.0 - initial release
// ============================================================================

module tb_bmc_soft_n;

    typedef struct packed {
        logic [15:0] bm;
        logic [1:0]  best;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic        out_ready = 1'b1;
    logic [5:0]  in_soft = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_bm;
    logic [1:0]  out_best;

    logic        hd_valid = 1'b0;
    logic [1:0]  hd_soft = '0;
    logic        hd_in_ready;
    logic        hd_out_valid;
    logic [7:0]  hd_bm;
    logic [1:0]  hd_best;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          n_pop = 0;
    logic        acc_flag = 1'b0;
    logic [5:0]  bp_soft [5];

    always #5 clk = ~clk;

    bmc_soft_n #(.N(2), .SW(3)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_soft   (in_soft),
        .in_sof    (in_sof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bm    (out_bm),
        .out_best  (out_best)
    );

    bmc_soft_n #(.N(2), .SW(1)) u_hd (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (hd_valid),
        .in_ready  (hd_in_ready),
        .in_soft   (hd_soft),
        .in_sof    (1'b0),
        .out_valid (hd_out_valid),
        .out_ready (1'b1),
        .out_bm    (hd_bm),
        .out_best  (hd_best)
    );

`ifdef BMC_PUNCT_EN
    logic        pn_valid = 1'b0;
    logic        pn_sof = 1'b0;
    logic [5:0]  pn_soft = '0;
    logic        pn_in_ready;
    logic        pn_out_valid;
    logic [15:0] pn_bm;
    logic [1:0]  pn_best;

    bmc_soft_n #(.N(2), .SW(3), .PUNCT_LEN(2), .PUNCT_MASK(4'b0111)) u_pn (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (pn_valid),
        .in_ready  (pn_in_ready),
        .in_soft   (pn_soft),
        .in_sof    (pn_sof),
        .out_valid (pn_out_valid),
        .out_ready (1'b1),
        .out_bm    (pn_bm),
        .out_best  (pn_best)
    );
`endif

    // Reference metrics for N=2, SW=3, built from the per-bit distance definition.
    function automatic exp_t model(input logic [5:0] s);
        int   raw [4];
        int   b;
        int   mn;
        exp_t e;
        e = '0;
        for (int h = 0; h < 4; h++) begin
            raw[h] = 0;
            for (int i = 0; i < 2; i++) begin
                b = int'((s >> (3 * i)) & 6'd7);
                raw[h] += ((h >> i) & 1) != 0 ? (7 - b) : b;
            end
        end
        mn = raw[0];
        for (int h = 1; h < 4; h++) begin
            if (raw[h] < mn) begin
                mn     = raw[h];
                e.best = 2'(h);
            end
        end
        for (int h = 0; h < 4; h++) begin
            e.bm[h*4 +: 4] = 4'(raw[h] - mn);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: sample handshakes on the falling edge, return 1 after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL sb_underflow got=%0d exp=nonzero", sb.size());
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_bm", 32'(out_bm), 32'(e.bm));
                chk("sb_best", 32'(out_best), 32'(e.best));
                n_pop++;
            end
        end
        acc_flag = in_valid & in_ready;
        if (acc_flag) begin
            sb.push_back(model(in_soft));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_bm", 32'(out_bm), 32'd0);
        chk("rst_out_best", 32'(out_best), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_hd_valid", 32'(hd_out_valid), 32'd0);
        rst_n = 1'b1;
        tick();

        // Strong ones with in_sof set (no effect on metrics), plus latency.
        in_valid = 1'b1;
        in_sof   = 1'b1;
        in_soft  = {3'd7, 3'd7};
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        chk("lat1_valid", 32'(out_valid), 32'd0);
        tick();
        chk("lat2_valid", 32'(out_valid), 32'd1);
        chk("ones_bm", 32'(out_bm), 32'h077E);
        chk("ones_best", 32'(out_best), 32'd3);
        tick();

        // Tie between h0 and h3 at metric 7; h2 is the unique minimum.
        in_valid = 1'b1;
        in_soft  = {3'd4, 3'd3};
        tick();
        in_valid = 1'b0;
        tick();
        chk("tie_bm", 32'(out_bm), 32'h1021);
        chk("tie_best", 32'(out_best), 32'd2);
        tick();

        // Hard-decision instance: in_soft=01.
        hd_valid = 1'b1;
        hd_soft  = 2'b01;
        tick();
        hd_valid = 1'b0;
        for (int w = 0; w < 6 && hd_out_valid !== 1'b1; w++) tick();
        chk("hd_valid", 32'(hd_out_valid), 32'd1);
        chk("hd_bm", 32'(hd_bm), 32'h61);
        chk("hd_best", 32'(hd_best), 32'd1);
        tick();

        // Back-to-back stream at full rate.
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_soft  = 6'($urandom_range(63, 0));
            chk("tput_ready", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("tput_drained", 32'(sb.size()), 32'd0);

        // Backpressure: two accepts fill the pipe, then in_ready drops.
        for (int k = 0; k < 5; k++) bp_soft[k] = 6'($urandom_range(63, 0));
        p0        = n_pop;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_soft   = bp_soft[0];
        tick();
        chk("bp_acc0", 32'(acc_flag), 32'd1);
        in_soft = bp_soft[1];
        tick();
        chk("bp_acc1", 32'(acc_flag), 32'd1);
        in_soft = bp_soft[2];
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bp_no_acc", 32'(acc_flag), 32'd0);
            chk("bp_ready_low", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_bm", 32'(out_bm), 32'(sb[0].bm));
            chk("bp_hold_best", 32'(out_best), 32'(sb[0].best));
        end
        out_ready = 1'b1;
        for (int k = 2; k < 5; k++) begin
            in_soft = bp_soft[k];
            acc_flag = 1'b0;
            for (int w = 0; w < 10 && acc_flag !== 1'b1; w++) tick();
            chk("bp_acc_late", 32'(acc_flag), 32'd1);
        end
        in_valid = 1'b0;
        for (int w = 0; w < 10 && (sb.size() != 0 || out_valid === 1'b1); w++) tick();
        chk("bp_count", 32'(n_pop - p0), 32'd5);
        chk("bp_sb_empty", 32'(sb.size()), 32'd0);

`ifdef BMC_PUNCT_EN
        // Phase 0 transmits both bits; phase 1 erases bit 1.
        pn_valid = 1'b1;
        pn_sof   = 1'b1;
        pn_soft  = {3'd7, 3'd7};
        tick();
        pn_sof = 1'b0;
        tick();
        pn_valid = 1'b0;
        chk("pn_ph0_bm", 32'(pn_bm), 32'h077E);
        chk("pn_ph0_best", 32'(pn_best), 32'd3);
        tick();
        chk("pn_ph1_valid", 32'(pn_out_valid), 32'd1);
        chk("pn_ph1_bm", 32'(pn_bm), 32'h0707);
        chk("pn_ph1_best", 32'(pn_best), 32'd1);
        tick();
`endif

        // Asynchronous reset with two symbols in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_soft   = 6'o52;
        tick();
        in_soft = 6'o17;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_bm", 32'(out_bm), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("post_rst_idle", 32'(out_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/bmc_soft_n.md
# bmc_soft_n

Parametrised soft-decision branch metric computation unit for the Viterbi decoder. Each accepted received symbol of N soft bits produces a metric for each of the 2^N codeword hypotheses, normalised so the best hypothesis scores 0. The block sits between the demodulator/depuncture front end and the add-compare-select array, with valid/ready flow control on both sides. It generalises the hard-decision rate-1/2 unit: with N=2, SW=1 and normalisation bypassed, metrics equal the Hamming distances.

## Interface
- N, default 2: code bits per symbol (1/N code rate); 2..4.
- SW, default 3: soft-bit width; 1..6. Offset binary: 0 = strong '0', 2^SW-1 = strong '1'.
- PUNCT_LEN, default 2: puncture period in symbols. Used only with BMC_PUNCT_EN.
- PUNCT_MASK, default all ones: PUNCT_LEN*N bits; bit p*N+i = 1 means bit i of phase-p symbol is transmitted.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input symbol valid.
- in_ready  out  1  block accepts a symbol this cycle.
- in_soft  in  N*SW  soft bits; bit i in slice [i*SW +: SW].
- in_sof  in  1  first symbol of a frame; qualified by in_valid.
- out_valid  out  1  metrics valid.
- out_ready  in  1  downstream accepts the metrics.
- out_bm  out  2^N*MW  metric of hypothesis h in slice [h*MW +: MW]; bit i of h is the expected code bit i.
- out_best  out  N  index of the minimum-metric hypothesis.

## Operation
- MW = clog2(N*(2^SW-1)+1); for example, N=2,SW=3 gives MW=4, and N=2,SW=1 gives MW=2.
- Per-bit distance: for expected bit 0, d = in_soft_i; for expected bit 1, d = (2^SW-1) - in_soft_i. Raw metric is the unsigned sum over i of d, with no saturation because MW covers the maximum.
- Stage 1 registers the 2^N raw metrics.
- Stage 2 finds the minimum and argmin, then registers out_bm = raw - min and out_best = argmin.
- On a tie, out_best takes the lowest index.
- A transfer occurs on in_valid & in_ready, or on out_valid & out_ready.
- The pipeline advances as a whole when advance = ~out_valid | out_ready, or when stage 1 is empty.
- in_ready = ~s1_valid | advance. in_ready may depend combinationally on out_ready.
- Outputs hold stable while out_valid & ~out_ready.
- in_soft is ignored when in_valid is 0.
- The metric content of in_sof is ignored unless BMC_PUNCT_EN is defined.

## Timing
- Latency is 2 cycles, from input accept to out_valid, when there is no stall.
- Sustained throughput is 1 symbol per cycle.
- Reset clears out_valid, s1_valid, out_bm (all zeros), out_best, and the puncture phase (0).
- Reset mid-operation discards in-flight symbols; no output appears after rst_n deasserts until new input arrives.
- With out_ready held low, at most 2 symbols are buffered, after which in_ready drops.
- On a simultaneous accept and emit with a full pipeline, both transfers occur in the same cycle with no bubble.

## Configuration
- BMC_PUNCT_EN defined:
  - A phase counter (clog2(PUNCT_LEN) bits) advances on each accepted input and wraps from PUNCT_LEN-1 to 0.
  - An accepted symbol with in_sof uses phase 0, and the counter becomes 1 (mod PUNCT_LEN).
  - Bits with a mask of 0 at the current phase contribute d=0 to every hypothesis (erasure).
- BMC_PUNCT_EN undefined: no counter, all bits always contribute, and PUNCT_LEN/PUNCT_MASK are unused.

## Structure
- Package bmc_pkg holds:
  - the bm_width(N,SW) constant function;
  - the soft-bit and metric typedefs;
  - the SW_MAX = 2^SW-1 helper.
- Sub-module bmc_min_tree: combinational min/argmin over 2^N metrics with lowest-index tie-break, used in stage 2.

## Test plan
- Hard-decision case (N=2, SW=1) with in_soft=2'b01:
  - raw metrics are h0=1, h1=0, h2=2, h3=1;
  - outputs are out_bm={1,0,2,1}... normalised, and out_best=1.
- Soft strong-ones case (N=2, SW=3) with in_soft={7,7}: out_bm h3=0, h1=h2=7, h0=14, and out_best=3.
- Tie case with in_soft={3,4} (SW=3):
  - raw metrics are h0=7, h1=8, h2=6, h3=7;
  - outputs are out_bm={1,2,0,1} and out_best=2.
- Backpressure: stream 5 symbols with out_ready held low 4 cycles.
  - in_ready drops after 2 accepts.
  - Outputs stay stable while stalled.
  - All 5 emerge in order, with none lost or duplicated.
- Puncturing (BMC_PUNCT_EN, N=2, PUNCT_LEN=2, PUNCT_MASK=4'b0111), with in_sof on the first symbol:
  - the phase-1 symbol has bit 1 erased;
  - with in_soft={7,7} on that symbol, h1 and h3 both read 0.
- Reset: assert rst_n low with 2 symbols in flight. out_valid drops immediately, and no stale output follows deassertion.
